hazard_ctrl_unit: RTL and testbench

- Centralised hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Replaces the fixed 2-source forwarding unit with an N-source forwarding selector.
- Adds load-use interlock, taken-branch flush and a variable-latency data-memory wait FSM with timeout.
- Drives stall, bubble and flush controls of the PC and the four pipeline registers, plus the EX operand forwarding mux selects.

---
 rtl/hz_pkg.sv | 16 +
 rtl/hz_fwd_sel.sv | 36 +++
 rtl/hazard_ctrl_unit.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hz_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   FWD_* : EX operand forwarding mux selects.
//   hz_state_e : hazard FSM states, visible on hz_state of hazard_ctrl_unit.
package hz_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB write data
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM ALU result

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hz_fwd_sel.sv
// Forwarding select for a single EX source operand.
// Ports:
//   ex_rs_i                    : source register of the EX instruction
//   mem_rd_i/mem_regwrite_i/mem_memread_i : producer currently in MEM
//   wb_rd_i/wb_regwrite_i      : producer currently in WB
//   sel_o                      : FWD_MEM / FWD_WB / FWD_RF
module hz_fwd_sel
  import hz_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_memread_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwrite_i,
  output logic [1:0]        sel_o
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no ALU result to forward; its data arrives from WB later.
  assign mem_hit = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)
                   && !mem_memread_i;
  assign wb_hit  = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i);

  // The MEM producer is younger, so it wins a double match.
  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit)     sel_o = FWD_MEM;
    else if (wb_hit) sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Centralised hazard controller for a 5-stage MIPS pipeline.
// Forwarding selects for every EX source, load-use interlock, taken-branch
// flush and a data-memory wait FSM with timeout. Priority each cycle:
// memory wait > branch flush > load-use.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   id_rs/id_src_used           : ID instruction sources and their valids
//   ex_rs                       : EX instruction sources (forwarding)
//   ex_/mem_/wb_rd, *_regwrite  : destination regs and write enables
//   ex_memread, mem_memread     : load present in EX / MEM
//   br_taken                    : branch resolved taken in MEM
//   dmem_req, dmem_ack          : MEM stage data-memory handshake; the access
//                                 completes in the cycle where both are high
//   fwd_sel                     : 2 bits per source (hz_pkg FWD_*)
//   *_stall, *_bubble, *_flush  : pipeline register controls
//   mem_err                     : sticky memory-timeout flag
//   hz_state                    : registered FSM state (hz_pkg hz_state_e)
// Optional build macro HZ_PERF_EN adds perf_stall_cnt / perf_flush_cnt.
module hazard_ctrl_unit
  import hz_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int REG_AW      = 5,
  parameter int BR_FLUSH    = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      ex_regwrite,
  input  logic                      mem_regwrite,
  input  logic                      wb_regwrite,
  input  logic                      ex_memread,
  input  logic                      mem_memread,
  input  logic                      br_taken,
  input  logic                      dmem_req,
  input  logic                      dmem_ack,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      pc_stall,
  output logic                      ifid_stall,
  output logic                      idex_stall,
  output logic                      exmem_stall,
  output logic                      idex_bubble,
  output logic                      memwb_bubble,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      exmem_flush,
  output logic                      mem_err,
`ifdef HZ_PERF_EN
  output logic [15:0]               perf_stall_cnt,
  output logic [15:0]               perf_flush_cnt,
`endif
  output logic [1:0]                hz_state
);

  localparam logic [7:0] TMO         = 8'(MEM_TIMEOUT);
  localparam logic       FLUSH_IDEX  = (BR_FLUSH >= 2);
  localparam logic       FLUSH_EXMEM = (BR_FLUSH >= 3);

  hz_state_e      state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [NUM_SRC*2-1:0] fwd_c;

  logic lu_hit, mem_wait, mem_tmo;
  logic pc_stall_c, ifid_stall_c, idex_stall_c, exmem_stall_c;
  logic idex_bubble_c, memwb_bubble_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    hz_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
      .ex_rs_i        (ex_rs[g*REG_AW +: REG_AW]),
      .mem_rd_i       (mem_rd),
      .mem_regwrite_i (mem_regwrite),
      .mem_memread_i  (mem_memread),
      .wb_rd_i        (wb_rd),
      .wb_regwrite_i  (wb_regwrite),
      .sel_o          (fwd_c[2*g +: 2])
    );
  end

  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_rs[i*REG_AW +: REG_AW] == ex_rd)) lu_hit = 1'b1;
    end
    lu_hit = lu_hit && ex_memread && ex_regwrite && (ex_rd != '0);
  end

  assign mem_wait = dmem_req && !dmem_ack && (cnt_q <  TMO);
  assign mem_tmo  = dmem_req && !dmem_ack && (cnt_q >= TMO);

  // Next state and controls. The state itself does not steer decisions: a
  // held pipeline is simply re-evaluated when the memory wait releases, and
  // LU_STALL cannot re-match because ID/EX now holds a bubble.
  always_comb begin
    state_d        = ST_RUN;
    cnt_d          = '0;
    err_d          = err_q;
    pc_stall_c     = 1'b0;
    ifid_stall_c   = 1'b0;
    idex_stall_c   = 1'b0;
    exmem_stall_c  = 1'b0;
    idex_bubble_c  = 1'b0;
    memwb_bubble_c = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_flush_c   = 1'b0;
    exmem_flush_c  = 1'b0;
    if (mem_wait) begin
      state_d        = ST_MEM_WAIT;
      cnt_d          = cnt_q + 8'd1;
      pc_stall_c     = 1'b1;
      ifid_stall_c   = 1'b1;
      idex_stall_c   = 1'b1;
      exmem_stall_c  = 1'b1;
      memwb_bubble_c = 1'b1;
    end else begin
      // A timeout releases exactly like an ack, only flagging the error.
      if (mem_tmo) err_d = 1'b1;
      if (br_taken) begin
        ifid_flush_c  = 1'b1;
        idex_flush_c  = FLUSH_IDEX;
        exmem_flush_c = FLUSH_EXMEM;
      end else if (lu_hit) begin
        state_d       = ST_LU_STALL;
        pc_stall_c    = 1'b1;
        ifid_stall_c  = 1'b1;
        idex_bubble_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Controls are held inactive for as long as reset is asserted.
  assign fwd_sel      = rst_n ? fwd_c : '0;
  assign pc_stall     = rst_n & pc_stall_c;
  assign ifid_stall   = rst_n & ifid_stall_c;
  assign idex_stall   = rst_n & idex_stall_c;
  assign exmem_stall  = rst_n & exmem_stall_c;
  assign idex_bubble  = rst_n & idex_bubble_c;
  assign memwb_bubble = rst_n & memwb_bubble_c;
  assign ifid_flush   = rst_n & ifid_flush_c;
  assign idex_flush   = rst_n & idex_flush_c;
  assign exmem_flush  = rst_n & exmem_flush_c;
  assign mem_err      = err_q;
  assign hz_state     = state_q;

`ifdef HZ_PERF_EN
  logic [15:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pc_stall && (perf_stall_q != 16'hFFFF))   perf_stall_q <= perf_stall_q + 16'd1;
      if (ifid_flush && (perf_flush_q != 16'hFFFF)) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit (NUM_SRC=2, BR_FLUSH=3, MEM_TIMEOUT=4).
// Each vector's expected output word is queued by the driver; a monitor on
// the falling edge pops and compares against the live DUT outputs.
// Output word: {fwd_sel[3:0], pc,ifid,idex,exmem stall, idex_bubble,
//               memwb_bubble, ifid,idex,exmem flush, mem_err, hz_state[1:0]}
module tb_hazard_ctrl_unit;

  localparam int W = 16;
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b110010000;
  localparam logic [8:0] C_MW   = 9'b111101000;
  localparam logic [8:0] C_BR   = 9'b000000111;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] id_rs = '0, ex_rs = '0;
  logic [1:0] id_src_used = '0;
  logic [4:0] ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic ex_regwrite = 0, mem_regwrite = 0, wb_regwrite = 0;
  logic ex_memread = 0, mem_memread = 0, br_taken = 0;
  logic dmem_req = 0, dmem_ack = 0;
  logic [3:0] fwd_sel;
  logic pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic idex_bubble, memwb_bubble, ifid_flush, idex_flush, exmem_flush, mem_err;
  logic [1:0] hz_state;
`ifdef HZ_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_ctrl_unit #(.NUM_SRC(2), .REG_AW(5), .BR_FLUSH(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_src_used(id_src_used),
    .ex_rs(ex_rs), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_memread(ex_memread), .mem_memread(mem_memread), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .fwd_sel(fwd_sel),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mem_err(mem_err),
`ifdef HZ_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .hz_state(hz_state)
  );

  logic [W-1:0] act_v;
  assign act_v = {fwd_sel, pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble,
                  memwb_bubble, ifid_flush, idex_flush, exmem_flush, mem_err, hz_state};

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] mk(input logic [3:0] f, input logic [8:0] c,
                                      input logic e, input logic [1:0] st);
    return {f, c, e, st};
  endfunction

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic clear_inputs();
    id_rs = '0; ex_rs = '0; id_src_used = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0;
    ex_memread = 0; mem_memread = 0; br_taken = 0;
    dmem_req = 0; dmem_ack = 0;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] ev;
    string nm;
    if (exp_q.size() != 0) begin
      ev = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (act_v !== ev) begin
        bad++;
        $display("FAIL %s: got %b want %b", nm, act_v, ev);
      end
    end
  end

  initial begin
    // reset held: controls gated even with a branch request present
    cyc(); cyc();
    br_taken = 1; dmem_req = 1;
    expect_out("reset", mk(4'b0000, C_NONE, 0, 2'b00));
    cyc(); rst_n = 1; clear_inputs();
    expect_out("idle", mk(4'b0000, C_NONE, 0, 2'b00));

    // forwarding
    cyc(); ex_rs = {5'd0, 5'd3}; mem_rd = 5'd3; mem_regwrite = 1; wb_rd = 5'd3; wb_regwrite = 1;
    expect_out("fwd_mem_wins", mk(4'b0010, C_NONE, 0, 2'b00));
    cyc(); mem_memread = 1;
    expect_out("fwd_load_skip", mk(4'b0001, C_NONE, 0, 2'b00));
    cyc(); mem_memread = 0; ex_rs = {5'd3, 5'd3};
    expect_out("fwd_both_mem", mk(4'b1010, C_NONE, 0, 2'b00));
    cyc(); mem_regwrite = 0;
    expect_out("fwd_wb_only", mk(4'b0101, C_NONE, 0, 2'b00));
    cyc(); ex_rs = {5'd7, 5'd3}; mem_regwrite = 1; mem_rd = 5'd7;
    expect_out("fwd_mixed", mk(4'b1001, C_NONE, 0, 2'b00));
    cyc(); ex_rs = '0; mem_rd = '0; wb_rd = '0;
    expect_out("fwd_r0", mk(4'b0000, C_NONE, 0, 2'b00));

    // load-use interlock
    cyc(); clear_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_rs = {5'd5, 5'd1}; id_src_used = 2'b11;
    expect_out("lu_stall", mk(4'b0000, C_LU, 0, 2'b00));
    cyc(); ex_memread = 0; ex_regwrite = 0; ex_rd = '0;
    mem_rd = 5'd5; mem_regwrite = 1; mem_memread = 1;
    expect_out("lu_state", mk(4'b0000, C_NONE, 0, 2'b01));
    cyc(); clear_inputs();
    ex_rs = {5'd5, 5'd1}; ex_regwrite = 1; ex_rd = 5'd9; wb_rd = 5'd5; wb_regwrite = 1;
    expect_out("lu_fwd_wb", mk(4'b0100, C_NONE, 0, 2'b00));
    cyc(); clear_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_rs = {5'd5, 5'd2}; id_src_used = 2'b01;
    expect_out("lu_unused_src", mk(4'b0000, C_NONE, 0, 2'b00));
    cyc(); ex_rd = '0; id_rs = '0; id_src_used = 2'b11;
    expect_out("lu_rd0", mk(4'b0000, C_NONE, 0, 2'b00));

    // taken branch overrides a load-use match
    cyc(); ex_rd = 5'd5; id_rs = {5'd1, 5'd5}; br_taken = 1;
    expect_out("br_flush", mk(4'b0000, C_BR, 0, 2'b00));
    cyc(); clear_inputs();
    expect_out("br_state_run", mk(4'b0000, C_NONE, 0, 2'b00));

    // memory wait acked after 3 cycles; branch and load-use ignored meanwhile
    cyc(); dmem_req = 1; br_taken = 1;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd6; id_rs = {5'd0, 5'd6}; id_src_used = 2'b01;
    expect_out("mw_1", mk(4'b0000, C_MW, 0, 2'b00));
    cyc(); br_taken = 0;
    expect_out("mw_2", mk(4'b0000, C_MW, 0, 2'b10));
    cyc();
    expect_out("mw_3", mk(4'b0000, C_MW, 0, 2'b10));
    cyc(); clear_inputs(); dmem_req = 1; dmem_ack = 1;
    expect_out("mw_ack", mk(4'b0000, C_NONE, 0, 2'b10));
    cyc(); dmem_req = 0; dmem_ack = 0;
    expect_out("mw_done", mk(4'b0000, C_NONE, 0, 2'b00));
    cyc(); dmem_req = 1; dmem_ack = 1;
    expect_out("mw_ack_run", mk(4'b0000, C_NONE, 0, 2'b00));

    // timeout: 4 stall cycles, forced release, sticky error
    cyc(); dmem_ack = 0;
    expect_out("to_1", mk(4'b0000, C_MW, 0, 2'b00));
    for (int i = 2; i <= 4; i++) begin
      cyc();
      expect_out($sformatf("to_%0d", i), mk(4'b0000, C_MW, 0, 2'b10));
    end
    cyc();
    expect_out("to_release", mk(4'b0000, C_NONE, 0, 2'b10));
    cyc(); dmem_req = 0;
    expect_out("to_err_set", mk(4'b0000, C_NONE, 1, 2'b00));
    cyc(); ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd4; id_rs = {5'd4, 5'd0}; id_src_used = 2'b10;
    expect_out("to_err_lu", mk(4'b0000, C_LU, 1, 2'b00));
    cyc(); clear_inputs();
    expect_out("err_lu_state", mk(4'b0000, C_NONE, 1, 2'b01));

    // reset asserted in the middle of a memory wait
    cyc(); dmem_req = 1;
    expect_out("rw_1", mk(4'b0000, C_MW, 1, 2'b00));
    cyc();
    expect_out("rw_2", mk(4'b0000, C_MW, 1, 2'b10));
    cyc(); rst_n = 0; br_taken = 1; ex_rs = {5'd0, 5'd3}; mem_rd = 5'd3; mem_regwrite = 1;
    expect_out("rst_mid_wait", mk(4'b0000, C_NONE, 0, 2'b00));
`ifdef HZ_PERF_EN
    #1;
    total++;
    if (perf_stall_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) begin
      bad++;
      $display("FAIL perf_reset: got stall=%0d flush=%0d want 0 0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    cyc(); rst_n = 1; clear_inputs();
    expect_out("rst_release", mk(4'b0000, C_NONE, 0, 2'b00));

    cyc(); cyc();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
